// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sync_debounce
//  Description : Input conditioner for raw asynchronous signals (pushbuttons,
//                switches, off-chip strobes). The input is brought into the
//                i_clk domain through a flop chain, then debounced. A change is
//                accepted only after DEBOUNCE_CYC consecutive equal
//                synchronised samples.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SYNC_STAGES   number of synchroniser flops (>= 2)
//    DEBOUNCE_CYC  consecutive equal samples needed to accept a change (>= 2)
//  Ports
//    i_clk    in   clock
//    i_rstn   in   asynchronous, active-low reset
//    i_async  in   raw asynchronous input
//    i_en     in   debounce enable; 0 holds o_level and aborts a pending change
//    o_level  out  debounced level (registered)
//    o_rise   out  one-cycle pulse when o_level goes 0->1 (registered)
//    o_fall   out  one-cycle pulse when o_level goes 1->0 (registered)
//    o_busy   out  1 while a candidate change is being qualified (registered)
// ============================================================================
module sync_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_async,
    input  logic i_en,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    // The counter only has to reach DEBOUNCE_CYC-1, so $clog2 is sufficient.
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Synchroniser. It runs every cycle regardless of i_en. Only the last stage
    // is used downstream.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Debounce FSM. All outputs are registered alongside the state.
    // o_busy is loaded with "next state is a WAIT_* state".
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Pulses last for exactly one cycle.
            r_rise <= 1'b0;
            r_fall <= 1'b0;

            if (!i_en) begin
                // Abort any qualification in progress. Fall back to the idle
                // state that matches the level already accepted. This also
                // covers the cycle in which the qualifying sample arrives.
                r_cnt  <= '0;
                r_busy <= 1'b0;
                case (r_state)
                    WAIT_HIGH: r_state <= IDLE_LOW;
                    WAIT_LOW:  r_state <= IDLE_HIGH;
                    default:   r_state <= r_state;
                endcase
            end else begin
                case (r_state)
                    IDLE_LOW: begin
                        if (w_s) begin
                            r_state <= WAIT_HIGH;
                            r_cnt   <= C_CNT_ONE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end

                    WAIT_HIGH: begin
                        if (!w_s) begin
                            // Glitch rejected: return to idle without a pulse.
                            r_state <= IDLE_LOW;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == C_CNT_LAST) begin
                            r_state <= IDLE_HIGH;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_rise  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt + C_CNT_ONE;
                            r_busy  <= 1'b1;
                        end
                    end

                    IDLE_HIGH: begin
                        if (!w_s) begin
                            r_state <= WAIT_LOW;
                            r_cnt   <= C_CNT_ONE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end

                    WAIT_LOW: begin
                        if (w_s) begin
                            r_state <= IDLE_HIGH;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == C_CNT_LAST) begin
                            r_state <= IDLE_LOW;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt + C_CNT_ONE;
                            r_busy  <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_busy  = r_busy;

endmodule
`default_nettype wire
